// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with a registered valid/ready output
// bundle and a one-entry skid buffer, so stall_o back to fetch is a flop.
// Optional early JAL redirect to fetch is enabled by DECODE_JAL_EARLY_EN.
// With the macro undefined, jmp_s and PC_JMP are tied to zero and execute
// resolves JAL through flush.
module decode_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [31:0]      NOP_INSN = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      INS_I,
    input  logic [XLEN-1:0]  PC_I,
    input  logic             ins_valid,
    output logic             stall_o,
    input  logic             flush,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [31:0]      INS_O,
    output logic [XLEN-1:0]  PC_O,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic             illegal_o,
    output logic [XLEN-1:0]  PC_JMP,
    output logic             jmp_s
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    // Source select for the output bundle on the next edge.
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_IN   = 2'b01;
    localparam logic [1:0] SEL_SKID = 2'b10;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    // Opcode map.
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Immediate generator; illegal opcodes, OP and MISC-MEM give zero.
    function automatic logic [31:0] gen_imm(input logic [31:0] ins);
        logic [31:0] res;
        res = 32'h00000000;
        if (ins[1:0] != 2'b11) begin
            res = 32'h00000000;
        end else begin
            case (ins[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                    res = {{20{ins[31]}}, ins[31:20]};
                OPC_STORE:
                    res = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                OPC_BRANCH:
                    res = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                OPC_LUI, OPC_AUIPC:
                    res = {ins[31:12], 12'h000};
                OPC_JAL:
                    res = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                default:
                    res = 32'h00000000;
            endcase
        end
        return res;
    endfunction

    // Any opcode outside the RV32I base map, or a compressed-looking low pair.
    function automatic logic is_illegal(input logic [31:0] ins);
        logic res;
        res = 1'b1;
        if (ins[1:0] != 2'b11) begin
            res = 1'b1;
        end else begin
            case (ins[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_STORE,
                OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP,
                OPC_MISC_MEM:
                    res = 1'b0;
                default:
                    res = 1'b1;
            endcase
        end
        return res;
    endfunction

    state_t            state;
    state_t            state_n;
    logic [1:0]        out_sel;
    logic              skid_load;
    logic              accept;
    logic              kill;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_illegal;

    logic [31:0]       skid_ins;
    logic [XLEN-1:0]   skid_pc;
    logic [XLEN-1:0]   skid_imm;
    logic              skid_illegal;

    // Decode of the incoming word and the accept qualifier.
    always_comb begin
        dec_imm     = gen_imm(INS_I);
        dec_illegal = is_illegal(INS_I);
        accept      = ins_valid & ~stall_o & ~flush & ~kill;
    end

    // Next-state and output-bundle source selection; flush dominates.
    always_comb begin
        state_n   = state;
        out_sel   = SEL_HOLD;
        skid_load = 1'b0;
        if (flush) begin
            state_n = EMPTY;
            out_sel = SEL_CLR;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = FULL;
                        out_sel = SEL_IN;
                    end else begin
                        state_n = EMPTY;
                        out_sel = SEL_HOLD;
                    end
                end
                FULL: begin
                    if (accept && ready_i) begin
                        state_n = FULL;
                        out_sel = SEL_IN;
                    end else if (accept) begin
                        state_n   = SKID;
                        skid_load = 1'b1;
                    end else if (ready_i) begin
                        state_n = EMPTY;
                        out_sel = SEL_CLR;
                    end else begin
                        state_n = FULL;
                    end
                end
                SKID: begin
                    if (ready_i) begin
                        state_n = FULL;
                        out_sel = SEL_SKID;
                    end else begin
                        state_n = SKID;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    out_sel = SEL_CLR;
                end
            endcase
        end
    end

    // State register; stall_o is the registered "next state is SKID" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            stall_o <= 1'b0;
        end else begin
            state   <= state_n;
            stall_o <= (state_n == SKID);
        end
    end

    // Skid entry keeps the already-decoded bundle of the second instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_ins     <= 32'h00000000;
            skid_pc      <= {XLEN{1'b0}};
            skid_imm     <= {XLEN{1'b0}};
            skid_illegal <= 1'b0;
        end else if (skid_load) begin
            skid_ins     <= INS_I;
            skid_pc      <= PC_I;
            skid_imm     <= dec_imm;
            skid_illegal <= dec_illegal;
        end else begin
            skid_ins     <= skid_ins;
            skid_pc      <= skid_pc;
            skid_imm     <= skid_imm;
            skid_illegal <= skid_illegal;
        end
    end

    // Output bundle register: load from input, load from skid, clear, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o   <= 1'b0;
            INS_O     <= NOP_INSN;
            PC_O      <= {XLEN{1'b0}};
            opcode    <= 7'h00;
            rd        <= 5'h00;
            rs1       <= 5'h00;
            rs2       <= 5'h00;
            funct3    <= 3'h0;
            funct7    <= 7'h00;
            imm       <= {XLEN{1'b0}};
            illegal_o <= 1'b0;
        end else begin
            case (out_sel)
                SEL_IN: begin
                    valid_o   <= 1'b1;
                    INS_O     <= INS_I;
                    PC_O      <= PC_I;
                    opcode    <= INS_I[6:0];
                    rd        <= INS_I[11:7];
                    rs1       <= INS_I[19:15];
                    rs2       <= INS_I[24:20];
                    funct3    <= INS_I[14:12];
                    funct7    <= INS_I[31:25];
                    imm       <= dec_imm;
                    illegal_o <= dec_illegal;
                end
                SEL_SKID: begin
                    valid_o   <= 1'b1;
                    INS_O     <= skid_ins;
                    PC_O      <= skid_pc;
                    opcode    <= skid_ins[6:0];
                    rd        <= skid_ins[11:7];
                    rs1       <= skid_ins[19:15];
                    rs2       <= skid_ins[24:20];
                    funct3    <= skid_ins[14:12];
                    funct7    <= skid_ins[31:25];
                    imm       <= skid_imm;
                    illegal_o <= skid_illegal;
                end
                SEL_CLR: begin
                    valid_o   <= 1'b0;
                    INS_O     <= NOP_INSN;
                    PC_O      <= {XLEN{1'b0}};
                    opcode    <= 7'h00;
                    rd        <= 5'h00;
                    rs1       <= 5'h00;
                    rs2       <= 5'h00;
                    funct3    <= 3'h0;
                    funct7    <= 7'h00;
                    imm       <= {XLEN{1'b0}};
                    illegal_o <= 1'b0;
                end
                default: begin
                    valid_o   <= valid_o;
                    INS_O     <= INS_O;
                    PC_O      <= PC_O;
                    opcode    <= opcode;
                    rd        <= rd;
                    rs1       <= rs1;
                    rs2       <= rs2;
                    funct3    <= funct3;
                    funct7    <= funct7;
                    imm       <= imm;
                    illegal_o <= illegal_o;
                end
            endcase
        end
    end

`ifdef DECODE_JAL_EARLY_EN
    logic jal_take;

    // An accepted JAL triggers the early redirect; flush blocks it via accept.
    always_comb begin
        jal_take = accept & (INS_I[6:0] == OPC_JAL) & (INS_I[1:0] == 2'b11);
        kill     = jmp_s;
    end

    // One-cycle redirect pulse; target is held until the next accepted JAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jmp_s  <= 1'b0;
            PC_JMP <= {XLEN{1'b0}};
        end else if (jal_take) begin
            jmp_s  <= 1'b1;
            PC_JMP <= PC_I + dec_imm;
        end else begin
            jmp_s  <= 1'b0;
            PC_JMP <= PC_JMP;
        end
    end
`else
    assign kill   = 1'b0;
    assign jmp_s  = 1'b0;
    assign PC_JMP = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage. Define
// DECODE_JAL_EARLY_EN on both bench and RTL to exercise the early JAL path.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] INS_I;
    logic [31:0] PC_I;
    logic        ins_valid;
    logic        stall_o;
    logic        flush;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] INS_O;
    logic [31:0] PC_O;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal_o;
    logic [31:0] PC_JMP;
    logic        jmp_s;

    int vectors;
    int miscompares;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI1 = 32'h00500093;
    localparam logic [31:0] ADDI2 = 32'h00600113;
    localparam logic [31:0] ADDI3 = 32'h00700193;
    localparam logic [31:0] SW    = 32'h0020A623;
    localparam logic [31:0] JAL   = 32'hFF9FF06F;
    localparam logic [31:0] LUI   = 32'h123450B7;
    localparam logic [31:0] BEQ   = 32'hFE000EE3;

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .INS_I     (INS_I),
        .PC_I      (PC_I),
        .ins_valid (ins_valid),
        .stall_o   (stall_o),
        .flush     (flush),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .INS_O     (INS_O),
        .PC_O      (PC_O),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .illegal_o (illegal_o),
        .PC_JMP    (PC_JMP),
        .jmp_s     (jmp_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic v, input logic rdy, input logic fl);
        INS_I     = ins;
        PC_I      = pc;
        ins_valid = v;
        ready_i   = rdy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #3;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0h want 0", valid_o); end
        vectors++; if (INS_O !== NOP) begin miscompares++; $display("FAIL reset_ins: got %08h want %08h", INS_O, NOP); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0h want 0", stall_o); end
        vectors++; if ({opcode, rd, rs1, rs2, funct3, funct7, imm, illegal_o, PC_O} !== 101'h0) begin miscompares++; $display("FAIL reset_fields: some field nonzero, imm=%08h opcode=%02h", imm, opcode); end
        vectors++; if ({jmp_s, PC_JMP} !== 33'h0) begin miscompares++; $display("FAIL reset_jmp: got jmp_s=%0h PC_JMP=%08h want 0", jmp_s, PC_JMP); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_decode();
        drive(ADDI1, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL addi_valid: got %0h want 1", valid_o); end
        vectors++; if (opcode !== 7'h13) begin miscompares++; $display("FAIL addi_opcode: got %02h want 13", opcode); end
        vectors++; if (rd !== 5'd1) begin miscompares++; $display("FAIL addi_rd: got %0d want 1", rd); end
        vectors++; if (rs1 !== 5'd0) begin miscompares++; $display("FAIL addi_rs1: got %0d want 0", rs1); end
        vectors++; if (imm !== 32'd5) begin miscompares++; $display("FAIL addi_imm: got %08h want 5", imm); end
        vectors++; if (illegal_o !== 1'b0) begin miscompares++; $display("FAIL addi_illegal: got %0h want 0", illegal_o); end
        vectors++; if (INS_O !== ADDI1) begin miscompares++; $display("FAIL addi_ins: got %08h want %08h", INS_O, ADDI1); end
    endtask

    task automatic test_store_decode();
        drive(SW, 32'h4, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (opcode !== 7'h23) begin miscompares++; $display("FAIL sw_opcode: got %02h want 23", opcode); end
        vectors++; if (rs1 !== 5'd1) begin miscompares++; $display("FAIL sw_rs1: got %0d want 1", rs1); end
        vectors++; if (rs2 !== 5'd2) begin miscompares++; $display("FAIL sw_rs2: got %0d want 2", rs2); end
        vectors++; if (funct3 !== 3'd2) begin miscompares++; $display("FAIL sw_funct3: got %0d want 2", funct3); end
        vectors++; if (imm !== 32'd12) begin miscompares++; $display("FAIL sw_imm: got %08h want c", imm); end
        vectors++; if (PC_O !== 32'h4) begin miscompares++; $display("FAIL sw_pc: got %08h want 4", PC_O); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %0h want 0", valid_o); end
        vectors++; if (INS_O !== NOP) begin miscompares++; $display("FAIL drain_ins: got %08h want %08h", INS_O, NOP); end
    endtask

    task automatic test_imm_formats();
        drive(LUI, 32'h8, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (imm !== 32'h12345000) begin miscompares++; $display("FAIL lui_imm: got %08h want 12345000", imm); end
        vectors++; if (rd !== 5'd1) begin miscompares++; $display("FAIL lui_rd: got %0d want 1", rd); end
        drive(BEQ, 32'hC, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (imm !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL beq_imm: got %08h want fffffffc", imm); end
        vectors++; if (funct7 !== 7'h7F) begin miscompares++; $display("FAIL beq_funct7: got %02h want 7f", funct7); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(ADDI1, 32'h10, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b1 || INS_O !== ADDI1) begin miscompares++; $display("FAIL bp_first: got valid=%0h ins=%08h want 1 %08h", valid_o, INS_O, ADDI1); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL bp_stall0: got %0h want 0", stall_o); end
        drive(ADDI2, 32'h14, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL bp_stall1: got %0h want 1", stall_o); end
        vectors++; if (INS_O !== ADDI1) begin miscompares++; $display("FAIL bp_stable: got %08h want %08h", INS_O, ADDI1); end
        drive(ADDI3, 32'h18, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (stall_o !== 1'b1 || INS_O !== ADDI1) begin miscompares++; $display("FAIL bp_hold: got stall=%0h ins=%08h want 1 %08h", stall_o, INS_O, ADDI1); end
        drive(ADDI3, 32'h18, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (INS_O !== ADDI2 || valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_second: got ins=%08h valid=%0h want %08h 1", INS_O, valid_o, ADDI2); end
        vectors++; if (imm !== 32'd6 || rd !== 5'd2 || PC_O !== 32'h14) begin miscompares++; $display("FAIL bp_second_fields: got imm=%08h rd=%0d pc=%08h want 6 2 14", imm, rd, PC_O); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL bp_unstall: got %0h want 0", stall_o); end
        tick();
        vectors++; if (INS_O !== ADDI3 || imm !== 32'd7 || PC_O !== 32'h18) begin miscompares++; $display("FAIL bp_third: got ins=%08h imm=%08h pc=%08h want %08h 7 18", INS_O, imm, PC_O, ADDI3); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_nodup: got valid=%0h ins=%08h want 0", valid_o, INS_O); end
    endtask

    task automatic test_flush_skid();
        drive(ADDI1, 32'h20, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ADDI2, 32'h24, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL fl_enter_skid: got %0h want 1", stall_o); end
        drive(ADDI3, 32'h28, 1'b1, 1'b0, 1'b1);
        tick();
        vectors++; if (valid_o !== 1'b0 || stall_o !== 1'b0) begin miscompares++; $display("FAIL fl_clear: got valid=%0h stall=%0h want 0 0", valid_o, stall_o); end
        vectors++; if (INS_O !== NOP) begin miscompares++; $display("FAIL fl_nop: got %08h want %08h", INS_O, NOP); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL fl_no_resurrect: got valid=%0h ins=%08h want 0", valid_o, INS_O); end
    endtask

    task automatic test_illegal();
        drive(32'h00000000, 32'h30, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b1 || illegal_o !== 1'b1) begin miscompares++; $display("FAIL ill_zero: got valid=%0h illegal=%0h want 1 1", valid_o, illegal_o); end
        vectors++; if (imm !== 32'h0) begin miscompares++; $display("FAIL ill_zero_imm: got %08h want 0", imm); end
        drive(32'hFFF0007F, 32'h34, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (illegal_o !== 1'b1 || imm !== 32'h0) begin miscompares++; $display("FAIL ill_opc: got illegal=%0h imm=%08h want 1 0", illegal_o, imm); end
        drive(32'h0000000F, 32'h38, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (illegal_o !== 1'b0 || imm !== 32'h0) begin miscompares++; $display("FAIL fence_legal: got illegal=%0h imm=%08h want 0 0", illegal_o, imm); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_jal();
        drive(JAL, 32'h100, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b1 || INS_O !== JAL || rd !== 5'd0) begin miscompares++; $display("FAIL jal_flows: got valid=%0h ins=%08h rd=%0d", valid_o, INS_O, rd); end
        vectors++; if (imm !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL jal_imm: got %08h want fffffff8", imm); end
`ifdef DECODE_JAL_EARLY_EN
        vectors++; if (jmp_s !== 1'b1 || PC_JMP !== 32'h000000F8) begin miscompares++; $display("FAIL jal_pulse: got jmp_s=%0h PC_JMP=%08h want 1 f8", jmp_s, PC_JMP); end
        drive(ADDI1, 32'h104, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (jmp_s !== 1'b0 || PC_JMP !== 32'h000000F8) begin miscompares++; $display("FAIL jal_pulse_end: got jmp_s=%0h PC_JMP=%08h want 0 f8", jmp_s, PC_JMP); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL jal_kill: got valid=%0h ins=%08h want 0", valid_o, INS_O); end
        drive(JAL, 32'h200, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++; if (jmp_s !== 1'b0 || valid_o !== 1'b0 || PC_JMP !== 32'h000000F8) begin miscompares++; $display("FAIL jal_flush_same: got jmp_s=%0h valid=%0h PC_JMP=%08h want 0 0 f8", jmp_s, valid_o, PC_JMP); end
`else
        vectors++; if (jmp_s !== 1'b0 || PC_JMP !== 32'h0) begin miscompares++; $display("FAIL jal_tied: got jmp_s=%0h PC_JMP=%08h want 0 0", jmp_s, PC_JMP); end
        drive(ADDI1, 32'h104, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++; if (valid_o !== 1'b1 || INS_O !== ADDI1) begin miscompares++; $display("FAIL jal_nokill: got valid=%0h ins=%08h want 1 %08h", valid_o, INS_O, ADDI1); end
        drive(JAL, 32'h200, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++; if (valid_o !== 1'b0 || jmp_s !== 1'b0) begin miscompares++; $display("FAIL jal_flush_same: got valid=%0h jmp_s=%0h want 0 0", valid_o, jmp_s); end
`endif
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_skid();
        drive(ADDI1, 32'h40, 1'b1, 1'b0, 1'b0);
        tick();
        drive(ADDI2, 32'h44, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL rst_enter_skid: got %0h want 1", stall_o); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (valid_o !== 1'b0 || stall_o !== 1'b0 || jmp_s !== 1'b0) begin miscompares++; $display("FAIL rst_async: got valid=%0h stall=%0h jmp_s=%0h want 0 0 0", valid_o, stall_o, jmp_s); end
        vectors++; if (INS_O !== NOP) begin miscompares++; $display("FAIL rst_async_ins: got %08h want %08h", INS_O, NOP); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_after: got valid=%0h want 0", valid_o); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_decode();
        test_store_decode();
        test_imm_formats();
        test_back_to_back();
        test_flush_skid();
        test_illegal();
        test_jal();
        test_reset_mid_skid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage, directly downstream of fetch_stage.
- Consumes the fetched instruction word and its PC, splits it into register indices and control fields, and generates the sign-extended immediate.
- Presents a registered, valid/ready-handshaked bundle to execute.
- Has a one-entry skid buffer, so its stall output back to fetch is purely registered.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- NOP_INSN, 32'h00000013, value driven on INS_O whenever valid_o=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- INS_I  in  32  instruction word from fetch_stage INS_O.
- PC_I  in  32  PC of INS_I.
- ins_valid  in  1  INS_I/PC_I valid this cycle.
- stall_o  out  1  registered; 1 = decode not accepting, fetch holds INS_I/PC_I.
- flush  in  1  redirect from execute; kills all held and incoming instructions.
- ready_i  in  1  execute accepts the output bundle this cycle.
- valid_o  out  1  output bundle valid.
- INS_O  out  32  instruction word.
- PC_O  out  32  instruction PC.
- opcode  out  7  INS[6:0].
- rd  out  5  destination register index.
- rs1  out  5  source register 1 index.
- rs2  out  5  source register 2 index.
- funct3  out  3  function field.
- funct7  out  7  function field.
- imm  out  32  sign-extended immediate.
- illegal_o  out  1  opcode not RV32I.
- PC_JMP  out  32  early JAL target to fetch.
- jmp_s  out  1  one-cycle JAL redirect pulse to fetch.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all outputs 0, except INS_O=NOP_INSN. State=EMPTY.
- Accept condition: accept = ins_valid & ~stall_o & ~flush & ~kill.
- Latency: an accepted instruction reaches valid_o on the next edge (1 cycle).
- Output stability: when valid_o=1 and ready_i=0, the bundle holds stable.
- States and transitions (flush or rst has priority and forces EMPTY):
  - EMPTY: accept -> FULL.
  - FULL: accept & ready_i -> FULL (new bundle replaces old). accept & ~ready_i -> SKID (new instruction goes to skid). ~accept & ready_i -> EMPTY. Otherwise hold.
  - SKID: ready_i -> FULL (skid contents move to output). Otherwise hold. No accept is possible because stall_o=1.
- stall_o: 1 exactly in state SKID. Registered.
- Ordering: instruction order is always preserved.
- Immediate generation, by opcode:
  - I-type: LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011.
  - S-type: STORE 0100011.
  - B-type: BRANCH 1100011, bit0=0.
  - U-type: LUI 0110111, AUIPC 0010111, low 12 bits 0.
  - J-type: JAL 1101111, bit0=0.
  - OP 0110011 and MISC-MEM 0001111: imm=0.
  - All except U-type sign-extend from INS[31].
- Illegal detection: any other opcode, or INS[1:0]!=2'b11, sets illegal_o=1 and imm=0. The instruction still flows with valid_o=1.
- Field extraction: rd/rs1/rs2/funct3/funct7 are extracted unconditionally, even when unused.
- Skid entry: stores the already-decoded bundle, so no decode happens on the skid-to-output move.

Optional Feature:
- Macro: DECODE_JAL_EARLY_EN.
- Defined:
  - On accept of a JAL, jmp_s=1 for exactly the next cycle.
  - PC_JMP=PC_I+imm_J (mod 2^32) is registered in that same cycle and held until the next JAL.
  - The kill window is the cycle in which jmp_s=1. Any instruction offered during it is dropped: not accepted, no state change.
  - The JAL itself still flows to execute (rd link write).
  - flush during the jmp_s cycle: the pulse is still delivered.
  - flush in the same cycle as the JAL is offered: no pulse.
- Undefined: jmp_s tied 0, PC_JMP tied 0, no kill window; JAL is resolved by execute via flush.

Test Plan:
- Basic decode: ADDI 0x00500093, PC 0x0, ready_i=1 -> next cycle valid_o=1, opcode=0x13, rd=1, rs1=0, imm=5, illegal_o=0.
- Store decode: SW 0x0020A623, PC 0x4 -> rs1=1, rs2=2, funct3=2, imm=12.
- Backpressure: ready_i=0, offer 0x00500093, 0x00600113, 0x00700193 back-to-back -> stall_o=1 from the cycle after the 2nd is accepted; 3rd held by fetch. Raise ready_i -> valid_o sequence 0x00500093, 0x00600113, 0x00700193 with no loss or duplication.
- Early JAL (macro on): JAL 0xFF9FF06F at PC 0x100 -> jmp_s=1 one cycle, PC_JMP=0x000000F8. Instruction offered in that cycle is dropped.
- Flush in SKID: flush=1 -> next cycle valid_o=0, stall_o=0, INS_O=0x00000013.
- Illegal and reset: INS_I=0x00000000 -> valid_o=1, illegal_o=1, imm=0. Assert rst mid-SKID -> immediate (async) valid_o=0, stall_o=0, jmp_s=0.
